// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, types and writeback select encodings
package cpu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

  // Writeback result source select
  localparam logic WB_SEL_MEM  = 1'b1;
  localparam logic WB_SEL_CALC = 1'b0;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one register file read port with zero-register and write bypass
//
// Ports:
//   i_index          register index being read
//   i_array_word     array contents at i_index
//   i_write_en       effective write this cycle (already excludes suppressed writes)
//   i_rd             destination of the in-flight write
//   i_writeback_data value being written this cycle
//   o_data           resolved read data
module regfile_read_port #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] i_index,
  input  logic [DATA_WIDTH-1:0] i_array_word,
  input  logic                  i_write_en,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic [DATA_WIDTH-1:0] i_writeback_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  // Zero register outranks bypass, bypass outranks the stored value.
  always_comb begin
    o_data = i_array_word;
    if (ZERO_REG_EN && (i_index == '0)) begin
      o_data = '0;
    end else if (i_write_en && (i_index == i_rd)) begin
      o_data = i_writeback_data;
    end
  end

endmodule

// File: rtl/writeback_register_file.sv
// rtl/writeback_register_file.sv - writeback result select and 16-entry general register file
//
// Ports:
//   clk, reset                             clock, synchronous active-high reset
//   wre_writeback                          write request from writeback stage
//   select_writeback_data_mux_writeback    1 = memory data, 0 = calculated data
//   rd_writeback                           destination register
//   data_from_memory_writeback             load data
//   calc_data_writeback                    ALU result
//   rs1_decode, rs2_decode                 decode read indices
//   debug_addr                             debug read index
//   rs1_data, rs2_data                     decode read data (with same-cycle bypass)
//   debug_data                             debug read data (no bypass)
//   writeback_data                         selected writeback value (combinational)
//   writeback_commit                       pulse: a write committed on the previous edge
module writeback_register_file #(
  parameter int DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wre_writeback,
  input  logic                  select_writeback_data_mux_writeback,
  input  logic [ADDR_WIDTH-1:0] rd_writeback,
  input  logic [DATA_WIDTH-1:0] data_from_memory_writeback,
  input  logic [DATA_WIDTH-1:0] calc_data_writeback,
  input  logic [ADDR_WIDTH-1:0] rs1_decode,
  input  logic [ADDR_WIDTH-1:0] rs2_decode,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] debug_data,
  output logic [DATA_WIDTH-1:0] writeback_data,
  output logic                  writeback_commit
);

  import cpu_pkg::WB_SEL_MEM;

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_commit;
  logic                  w_write_en;

  assign writeback_data = (select_writeback_data_mux_writeback == WB_SEL_MEM) ?
                          data_from_memory_writeback : calc_data_writeback;

  // A write to the hardwired zero register is dropped entirely: no store,
  // no bypass, no commit pulse.
  assign w_write_en = wre_writeback & ~(ZERO_REG_EN & (rd_writeback == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_commit <= 1'b0;
    end else begin
      r_commit <= w_write_en;
      if (w_write_en) begin
        r_regs[rd_writeback] <= writeback_data;
      end
    end
  end

  assign writeback_commit = r_commit;

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG_EN(ZERO_REG_EN)
  ) u_rs1_port (
    .i_index         (rs1_decode),
    .i_array_word    (r_regs[rs1_decode]),
    .i_write_en      (w_write_en),
    .i_rd            (rd_writeback),
    .i_writeback_data(writeback_data),
    .o_data          (rs1_data)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG_EN(ZERO_REG_EN)
  ) u_rs2_port (
    .i_index         (rs2_decode),
    .i_array_word    (r_regs[rs2_decode]),
    .i_write_en      (w_write_en),
    .i_rd            (rd_writeback),
    .i_writeback_data(writeback_data),
    .o_data          (rs2_data)
  );

  // Debug view shows only committed state, so no bypass path here.
  assign debug_data = (ZERO_REG_EN && (debug_addr == '0)) ? '0 : r_regs[debug_addr];

endmodule

// File: tb/tb_writeback_register_file.sv
// tb/tb_writeback_register_file.sv - self-checking bench for writeback_register_file
module tb_writeback_register_file;
  import cpu_pkg::*;

  localparam int NUM = 2**ADDR_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     reset, wre, sel, commit;
  reg_idx_t rd, rs1, rs2, dbg;
  word_t    mem_d, calc_d, rs1_data, rs2_data, dbg_data, wb_data;

  writeback_register_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG_EN(1'b1)
  ) dut (
    .clk                                (clk),
    .reset                              (reset),
    .wre_writeback                      (wre),
    .select_writeback_data_mux_writeback(sel),
    .rd_writeback                       (rd),
    .data_from_memory_writeback         (mem_d),
    .calc_data_writeback                (calc_d),
    .rs1_decode                         (rs1),
    .rs2_decode                         (rs2),
    .debug_addr                         (dbg),
    .rs1_data                           (rs1_data),
    .rs2_data                           (rs2_data),
    .debug_data                         (dbg_data),
    .writeback_data                     (wb_data),
    .writeback_commit                   (commit)
  );

  typedef struct packed {
    logic     rst;
    logic     wre;
    logic     sel;
    reg_idx_t rd;
    word_t    mem;
    word_t    calc;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t dbg;
    word_t    e_rs1;
    word_t    e_rs2;
    word_t    e_dbg;
    word_t    e_wb;
    logic     e_commit;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents and pending commit flag
  word_t mdl [NUM];
  logic  m_commit;

  function automatic vec_t mk(logic rst_i, logic wre_i, logic sel_i, reg_idx_t rd_i,
                              word_t mem_i, word_t calc_i, reg_idx_t rs1_i, reg_idx_t rs2_i,
                              reg_idx_t dbg_i, word_t e1, word_t e2, word_t ed, word_t ew,
                              logic ec);
    vec_t v;
    v.rst = rst_i; v.wre = wre_i; v.sel = sel_i; v.rd = rd_i;
    v.mem = mem_i; v.calc = calc_i; v.rs1 = rs1_i; v.rs2 = rs2_i; v.dbg = dbg_i;
    v.e_rs1 = e1; v.e_rs2 = e2; v.e_dbg = ed; v.e_wb = ew; v.e_commit = ec;
    return v;
  endfunction

  function automatic word_t m_read(reg_idx_t idx, logic byp, logic wre_i, reg_idx_t rd_i,
                                   word_t wbv);
    if (idx == 0) return '0;
    if (byp && wre_i && rd_i != 0 && idx == rd_i) return wbv;
    return mdl[idx];
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mode 0: no check, 1: compare to the vector's expected fields, 2: compare to model
  task automatic run_cycle(input vec_t v, input int mode, input string tag);
    word_t wbx, x1, x2, xd;
    logic  xc;
    @(negedge clk);
    reset = v.rst; wre = v.wre; sel = v.sel; rd = v.rd;
    mem_d = v.mem; calc_d = v.calc; rs1 = v.rs1; rs2 = v.rs2; dbg = v.dbg;
    #1;
    wbx = v.sel ? v.mem : v.calc;
    if (mode == 1) begin
      x1 = v.e_rs1; x2 = v.e_rs2; xd = v.e_dbg; wbx = v.e_wb; xc = v.e_commit;
    end else begin
      x1 = m_read(v.rs1, 1'b1, v.wre, v.rd, wbx);
      x2 = m_read(v.rs2, 1'b1, v.wre, v.rd, wbx);
      xd = m_read(v.dbg, 1'b0, v.wre, v.rd, wbx);
      xc = m_commit;
    end
    if (mode != 0) begin
      check({tag, " rs1_data"}, rs1_data, x1);
      check({tag, " rs2_data"}, rs2_data, x2);
      check({tag, " debug_data"}, dbg_data, xd);
      check({tag, " writeback_data"}, wb_data, wbx);
      check({tag, " writeback_commit"}, {15'd0, commit}, {15'd0, xc});
    end
    @(posedge clk);
    wbx = v.sel ? v.mem : v.calc;
    if (v.rst) begin
      for (int i = 0; i < NUM; i++) mdl[i] = '0;
      m_commit = 1'b0;
    end else begin
      m_commit = v.wre && (v.rd != 0);
      if (m_commit) mdl[v.rd] = wbx;
    end
  endtask

  vec_t tbl [14];
  vec_t rv;

  initial begin
    reset = 1'b1; wre = 1'b0; sel = 1'b0; rd = '0; mem_d = '0; calc_d = '0;
    rs1 = '0; rs2 = '0; dbg = '0;
    m_commit = 1'b0;
    for (int i = 0; i < NUM; i++) mdl[i] = '0;

    //            rst  wre  sel  rd  mem      calc     rs1 rs2 dbg  e_rs1    e_rs2    e_dbg    e_wb     commit
    tbl[0]  = mk(1'b0,1'b0,1'b0,4'd0,16'h0000,16'h0000,4'd3,4'd15,4'd5,16'h0000,16'h0000,16'h0000,16'h0000,1'b0);
    tbl[1]  = mk(1'b0,1'b1,1'b0,4'd3,16'hBEEF,16'h1234,4'd3,4'd4,4'd3,16'h1234,16'h0000,16'h0000,16'h1234,1'b0);
    tbl[2]  = mk(1'b0,1'b0,1'b1,4'd3,16'hBEEF,16'h0000,4'd3,4'd3,4'd3,16'h1234,16'h1234,16'h1234,16'hBEEF,1'b1);
    tbl[3]  = mk(1'b0,1'b1,1'b1,4'd7,16'hA5A5,16'h1111,4'd7,4'd7,4'd7,16'hA5A5,16'hA5A5,16'h0000,16'hA5A5,1'b0);
    tbl[4]  = mk(1'b0,1'b0,1'b0,4'd7,16'h0000,16'h0000,4'd7,4'd3,4'd7,16'hA5A5,16'h1234,16'hA5A5,16'h0000,1'b1);
    tbl[5]  = mk(1'b0,1'b1,1'b0,4'd0,16'h0000,16'hFFFF,4'd0,4'd0,4'd0,16'h0000,16'h0000,16'h0000,16'hFFFF,1'b0);
    tbl[6]  = mk(1'b0,1'b0,1'b0,4'd0,16'h0000,16'h0000,4'd0,4'd7,4'd0,16'h0000,16'hA5A5,16'h0000,16'h0000,1'b0);
    tbl[7]  = mk(1'b0,1'b1,1'b0,4'd5,16'h0000,16'h0042,4'd5,4'd3,4'd5,16'h0042,16'h1234,16'h0000,16'h0042,1'b0);
    tbl[8]  = mk(1'b0,1'b0,1'b0,4'd5,16'h0000,16'h5555,4'd5,4'd5,4'd5,16'h0042,16'h0042,16'h0042,16'h5555,1'b1);
    tbl[9]  = mk(1'b0,1'b0,1'b1,4'd5,16'h0000,16'h0000,4'd5,4'd0,4'd5,16'h0042,16'h0000,16'h0042,16'h0000,1'b0);
    tbl[10] = mk(1'b0,1'b1,1'b0,4'd9,16'h0000,16'h0011,4'd9,4'd9,4'd9,16'h0011,16'h0011,16'h0000,16'h0011,1'b0);
    tbl[11] = mk(1'b0,1'b1,1'b1,4'd9,16'h2222,16'h0000,4'd9,4'd2,4'd9,16'h2222,16'h0000,16'h0011,16'h2222,1'b1);
    tbl[12] = mk(1'b1,1'b1,1'b0,4'd9,16'h0000,16'h7777,4'd9,4'd5,4'd9,16'h7777,16'h0042,16'h2222,16'h7777,1'b1);
    tbl[13] = mk(1'b0,1'b0,1'b0,4'd0,16'h0000,16'h0000,4'd9,4'd5,4'd9,16'h0000,16'h0000,16'h0000,16'h0000,1'b0);

    // Bring the design to a known state before any checking
    run_cycle(mk(1'b1,1'b0,1'b0,4'd0,16'h0,16'h0,4'd0,4'd0,4'd0,16'h0,16'h0,16'h0,16'h0,1'b0), 0, "init");

    for (int i = 0; i < 14; i++) begin
      run_cycle(tbl[i], 1, $sformatf("tbl%0d", i));
    end

    // Randomized traffic against the model; read indices are biased toward rd
    for (int n = 0; n < 400; n++) begin
      rv = '0;
      rv.rst  = ($urandom_range(0, 31) == 0);
      rv.wre  = ($urandom_range(0, 3) != 0);
      rv.sel  = 1'($urandom_range(0, 1));
      rv.rd   = 4'($urandom_range(0, NUM - 1));
      rv.mem  = 16'($urandom);
      rv.calc = 16'($urandom);
      rv.rs1  = $urandom_range(0, 1) ? rv.rd : 4'($urandom_range(0, NUM - 1));
      rv.rs2  = $urandom_range(0, 1) ? rv.rd : 4'($urandom_range(0, NUM - 1));
      rv.dbg  = $urandom_range(0, 1) ? rv.rd : 4'($urandom_range(0, NUM - 1));
      run_cycle(rv, 2, $sformatf("rnd%0d", n));
    end

    // Two reset cycles after random writes, then sweep the debug port
    for (int n = 0; n < 2; n++) begin
      rv = '0;
      rv.rst = 1'b1;
      rv.calc = 16'($urandom);
      run_cycle(rv, 0, "rst");
    end
    for (int i = 0; i < NUM; i++) begin
      rv = '0;
      rv.dbg = 4'(i);
      rv.rs1 = 4'(i);
      rv.rs2 = 4'(NUM - 1 - i);
      rv.calc = 16'($urandom);
      run_cycle(rv, 2, $sformatf("post_reset%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
